keypad_matrix_scan: RTL and testbench
=====================================

Name: keypad_matrix_scan

Overview:
Upstream stage of the keypad input path: drives the 4x4 keypad columns, samples the rows, debounces a single key press and emits a 4-bit key code with a one-cycle valid strobe. Its value/valid pair feeds the digit shift register (valid is that register's trig). One code per physical press; no auto-repeat.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (min 4).
DEBOUNCE, 8, consecutive matching samples required to accept a press or a release (min 1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
row  input  4  keypad rows, active-low (pulled up; pressed key in driven column pulls its row low); asynchronous to clk
col  output  4  column drive, one-hot active-low
value  output  4  key code of last accepted press
valid  output  1  one-cycle pulse when value is updated

Behaviour:
- Reset (async assert, takes effect immediately): col=4'b1110 (column 0), value=4'h0, valid=0, state=SCAN, dwell counter=0, debounce counter=0, synchroniser flops=4'hF.
- row passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- Dwell counter counts 0..SCAN_DIV-1 while a column is driven. A "sample" is taken when the counter equals SCAN_DIV-1; the counter then wraps to 0.
- Key map (row r, column c) -> value: r0: 1,2,3,A(10); r1: 4,5,6,B(11); r2: 7,8,9,C(12); r3: *(14),0,#(15),D(13).
- States:
  SCAN: at each sample: rs==4'hF or more than one row low -> advance to next column (3 wraps to 0), col updated the same cycle the counter wraps. Exactly one row low -> latch candidate (row, col), debounce count=1, go DEBOUNCE; col held.
  DEBOUNCE: col held. At each sample: rs equals the latched pattern -> count+1; count reaching DEBOUNCE -> go HOLD and register value plus valid=1 on that cycle. Any other pattern -> clear count, advance column, go SCAN.
  HOLD: col held; valid returns to 0 the following cycle. At each sample: rs==4'hF -> release count+1, else release count cleared. Release count reaching DEBOUNCE -> advance column, go SCAN.
- With DEBOUNCE=1 the candidate is accepted on the first sample (SCAN goes straight to HOLD with valid).
- valid is exactly one clk cycle wide; value is stable from that cycle until the next valid, and is never changed without valid.
- Second key pressed while in HOLD: ignored; no new code until full release is debounced.
- Key in another column pressed while in DEBOUNCE: invisible (column held); the first key alone decides.
- Glitch shorter than DEBOUNCE samples: no valid.
- Reset mid-DEBOUNCE or mid-HOLD: aborts immediately, no valid; a key still held after reset release is re-detected and produces exactly one valid.
- Latency (key already pressed and stable in column c, scan reaching c): valid asserts on the (DEBOUNCE)th sample of that column, i.e. DEBOUNCE*SCAN_DIV-1 cycles after column c is first driven.

Test Plan:
(SCAN_DIV=4, DEBOUNCE=3, keypad model shorts row r to col c when key pressed)
- Idle, no key, 40 cycles after reset -> col rotates 1110,1101,1011,0111,1110 every 4 cycles; valid stays 0; value=0.
- Hold key "5" (r1,c1) steady -> exactly one valid pulse with value=5, issued 11 cycles after col=1101 is first driven; col frozen at 1101 until release; no further valid while held 200 cycles.
- Press "#" for 2 samples then release -> no valid; scanning resumes.
- Press "D" (value 13), release, press "*" (value 14) -> two pulses, values 13 then 14; release debounced between them.
- Hold "1" and "9" simultaneously from reset -> single valid with value=1 (column 0 scanned first); no second pulse until both released.
- Assert reset while in HOLD for key "7", keep key held, deassert -> outputs at reset values during reset; one new valid with value=7 after re-detection.

Source files
------------

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner: rotates the active-low column drive, synchronises the rows,
// debounces one key press and release, and emits one key code per press with a 1-cycle strobe.
module keypad_matrix_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] value,
  output logic       valid
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE_ST = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  logic [3:0]    rs_meta, rs;
  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [3:0]    cand;
  logic [DW-1:0] dcnt;
  logic          sample, wrap, one_low, db_done;
  logic [1:0]    ridx, cidx;
  logic [3:0]    code;

  // Decisions land as the counter reaches SCAN_DIV-1 so the strobe falls in the
  // sample cycle itself; the column only moves at the following wrap.
  assign sample  = (cnt == CW'(SCAN_DIV - 2));
  assign wrap    = (cnt == CW'(SCAN_DIV - 1));
  assign db_done = ((dcnt + DW'(1)) == DW'(DEBOUNCE));

  always_comb begin
    one_low = 1'b1;
    ridx    = 2'd0;
    case (rs)
      4'b1110: ridx = 2'd0;
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    cidx = 2'd0;
    case (col)
      4'b1101: cidx = 2'd1;
      4'b1011: cidx = 2'd2;
      4'b0111: cidx = 2'd3;
      default: cidx = 2'd0;
    endcase
  end

  always_comb begin
    code = 4'h0;
    case ({ridx, cidx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
      cnt     <= '0;
      col     <= 4'b1110;
      state   <= SCAN;
      cand    <= 4'hF;
      dcnt    <= '0;
      value   <= 4'h0;
      valid   <= 1'b0;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
      valid   <= 1'b0;
      cnt     <= wrap ? '0 : cnt + CW'(1);
      if (wrap && state == SCAN) col <= {col[2:0], col[3]};
      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              cand <= rs;
              if (DEBOUNCE == 1) begin
                state <= HOLD;
                dcnt  <= '0;
                value <= code;
                valid <= 1'b1;
              end else begin
                state <= DEBOUNCE_ST;
                dcnt  <= DW'(1);
              end
            end
          end
          DEBOUNCE_ST: begin
            if (rs == cand) begin
              if (db_done) begin
                state <= HOLD;
                dcnt  <= '0;
                value <= code;
                valid <= 1'b1;
              end else begin
                dcnt <= dcnt + DW'(1);
              end
            end else begin
              state <= SCAN;
              dcnt  <= '0;
            end
          end
          HOLD: begin
            // Any non-idle sample restarts the release count.
            if (rs == 4'hF) begin
              if (db_done) begin
                state <= SCAN;
                dcnt  <= '0;
              end else begin
                dcnt <= dcnt + DW'(1);
              end
            end else begin
              dcnt <= '0;
            end
          end
          default: begin
            state <= SCAN;
            dcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan (SCAN_DIV=4, DEBOUNCE=3) with a
// keypad model that shorts row r to column c while key (r,c) is pressed.
module tb_keypad_matrix_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row, col, value;
  logic        valid;
  logic [15:0] keys;  // bit r*4+c

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int base, cyc;
  logic [3:0] vlast = 4'h0;
  logic       vprev = 1'b0;
  logic [3:0] e;

  keypad_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .value(value), .valid(valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts strobes and flags any strobe wider than one cycle.
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vlast = value;
      chk("valid_width", {31'd0, vprev}, 32'd0);
    end
    vprev = valid;
  end

  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (valid) begin n = i; break; end
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (col == target) break;
    end
  endtask

  initial begin
    keys  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'hE);
    chk("rst_value", value, 4'h0);
    chk("rst_valid", valid, 1'b0);

    // Idle rotation: column index advances every 4 cycles after reset release
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((n / 4) % 4));
      chk("idle_col", col, e);
    end
    chk("idle_vcount", vcount, 0);
    chk("idle_value", value, 4'h0);

    // Key 5 held steady: strobe 11 cycles after column 1 is first driven
    keys[5] = 1'b1;
    wait_col(4'hD, 40);
    chk("k5_col", col, 4'hD);
    wait_valid(40, cyc);
    chk("k5_latency", cyc, 11);
    chk("k5_value", value, 4'h5);
    repeat (200) @(negedge clk);
    chk("k5_held_col", col, 4'hD);
    chk("k5_once", vcount, 1);
    keys[5] = 1'b0;
    wait_col(4'hB, 40);
    chk("k5_resume", col, 4'hB);

    // Glitch on # (2 samples) while column 2 freshly driven: no strobe
    keys[14] = 1'b1;
    repeat (8) @(negedge clk);
    keys[14] = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_col", col, 4'h7);
    repeat (40) @(negedge clk);
    chk("glitch_vcount", vcount, 1);

    // D then *, with the release debounced in between
    base = vcount;
    keys[15] = 1'b1;
    wait_valid(100, cyc);
    chk("kD_seen", (cyc > 0), 1'b1);
    chk("kD_value", value, 4'hD);
    keys[15] = 1'b0;
    wait_col(4'hE, 60);
    chk("kD_release", col, 4'hE);
    chk("kD_count", vcount, base + 1);
    keys[12] = 1'b1;
    wait_valid(100, cyc);
    chk("kstar_latency", cyc, 11);
    chk("kstar_value", value, 4'hE);
    keys[12] = 1'b0;
    wait_col(4'hD, 60);
    chk("kstar_count", vcount, base + 2);
    chk("kstar_vlast", vlast, 4'hE);

    // 1 and 9 held from reset: column 0 wins, one strobe only
    reset = 1'b1;
    keys[0] = 1'b1;
    keys[10] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = vcount;
    wait_valid(40, cyc);
    chk("k19_latency", cyc, 11);
    chk("k19_value", value, 4'h1);
    repeat (100) @(negedge clk);
    chk("k19_once", vcount, base + 1);
    chk("k19_col", col, 4'hE);
    keys[10] = 1'b0;
    repeat (40) @(negedge clk);
    chk("k19_partial", vcount, base + 1);
    keys[0] = 1'b0;
    wait_col(4'hD, 60);
    repeat (60) @(negedge clk);
    chk("k19_after", vcount, base + 1);

    // Reset during HOLD on key 7, key kept held: one re-detected strobe
    keys[8] = 1'b1;
    wait_valid(100, cyc);
    chk("k7_value", value, 4'h7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("k7_rst_col", col, 4'hE);
    chk("k7_rst_value", value, 4'h0);
    chk("k7_rst_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("k7_rst_value2", value, 4'h0);
    reset = 1'b0;
    base = vcount;
    wait_valid(40, cyc);
    chk("k7_latency", cyc, 11);
    chk("k7_value2", value, 4'h7);
    repeat (30) @(negedge clk);
    chk("k7_once", vcount, base + 1);
    keys = '0;
    repeat (40) @(negedge clk);
    chk("final_value", value, 4'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
